multi_pulse_gen: RTL and testbench

Parametrised, multi-channel edge-to-pulse generator for front-panel push-buttons and step/run triggers feeding the soft-CPU wrapper (single-step, load, run strobes). Each channel synchronises an asynchronous trigger, debounces press and release, and emits a load pulse of programmable width once per press. Channels are independent and share only clock and reset.

---
 rtl/multi_pulse_gen_if.sv | 14 +
 rtl/multi_pulse_gen.sv | 173 +++++++++++++++++
 tb/tb_multi_pulse_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_pulse_gen_if.sv
// Trigger/load bundle shared by multi_pulse_gen and its driver.
// The slave side is the pulse generator; the master side drives enables and triggers.
interface multi_pulse_gen_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] load;
  logic                any_load;
  logic [CHANNELS-1:0] busy;

  modport master (output enable, output trigger, input load, input any_load, input busy);
  modport slave  (input enable, input trigger, output load, output any_load, output busy);
endinterface

// File: rtl/multi_pulse_gen.sv
// Multi-channel synchronise/debounce/edge-to-pulse generator with registered outputs.
// Optional auto-repeat while a press is held is compiled in with `define MPG_REPEAT_EN.
module multi_pulse_gen #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             clock,
  input  logic             reset,
  multi_pulse_gen_if.slave bus
);
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > PULSE_WIDTH) ? DEBOUNCE_CYCLES : PULSE_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS, PULSE, HOLD} state_t;

  logic [CHANNELS-1:0] load_vec;
  logic [CHANNELS-1:0] load_next_vec;
  logic [CHANNELS-1:0] busy_vec;
  logic                any_load_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      state_t                 state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   load_reg, load_next;
      logic                   busy_reg;
      logic                   s;
      logic                   start;
`ifdef MPG_REPEAT_EN
      localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int REP_W   = $clog2(REP_MAX + 1);
      // rep_reg counts cycles since the current pulse's first cycle, saturating
      logic [REP_W-1:0] rep_reg, rep_next;
      logic             rep_first_reg, rep_first_next;
`endif

      assign s = sync_reg[SYNC_STAGES-1];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_next  = load_reg;
        start      = 1'b0;
`ifdef MPG_REPEAT_EN
        rep_first_next = rep_first_reg;
        rep_next       = rep_reg;
        if (rep_reg != REP_W'(REP_MAX)) rep_next = rep_reg + REP_W'(1);
`endif
        if (!bus.enable[gi]) begin
          state_next = IDLE;
          cnt_next   = '0;
          load_next  = 1'b0;
`ifdef MPG_REPEAT_EN
          rep_next   = '0;
`endif
        end else begin
          case (state_reg)
            IDLE: begin
              cnt_next  = '0;
              load_next = 1'b0;
`ifdef MPG_REPEAT_EN
              rep_next       = '0;
              rep_first_next = 1'b1;
`endif
              if (s) begin
                if (DEBOUNCE_CYCLES == 1) begin
                  start = 1'b1;
                end else begin
                  state_next = PRESS;
                  cnt_next   = CNT_W'(1);
                end
              end
            end
            PRESS: begin
`ifdef MPG_REPEAT_EN
              rep_next = '0;
`endif
              if (!s) begin
                state_next = IDLE;
                cnt_next   = '0;
              end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                start = 1'b1;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
            PULSE: begin
              if (cnt_reg == CNT_W'(PULSE_WIDTH)) begin
                state_next = HOLD;
                load_next  = 1'b0;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg + CNT_W'(1);
              end
            end
            HOLD: begin
              // cnt_reg counts consecutive low samples while waiting for release
              if (!s) begin
                if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
                end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
                end
              end else begin
                cnt_next = '0;
`ifdef MPG_REPEAT_EN
                if (rep_reg >= (rep_first_reg ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD))) begin
                  start          = 1'b1;
                  rep_first_next = 1'b0;
                end
`endif
              end
            end
            default: state_next = IDLE;
          endcase
          if (start) begin
            state_next = PULSE;
            cnt_next   = CNT_W'(1);
            load_next  = 1'b1;
`ifdef MPG_REPEAT_EN
            rep_next   = REP_W'(1);
`endif
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          sync_reg  <= '0;
          state_reg <= IDLE;
          cnt_reg   <= '0;
          load_reg  <= 1'b0;
          busy_reg  <= 1'b0;
`ifdef MPG_REPEAT_EN
          rep_reg       <= '0;
          rep_first_reg <= 1'b1;
`endif
        end else begin
          sync_reg  <= {sync_reg[SYNC_STAGES-2:0], bus.trigger[gi]};
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          load_reg  <= load_next;
          busy_reg  <= (state_next != IDLE);
`ifdef MPG_REPEAT_EN
          rep_reg       <= rep_next;
          rep_first_reg <= rep_first_next;
`endif
        end
      end

      assign load_vec[gi]      = load_reg;
      assign load_next_vec[gi] = load_next;
      assign busy_vec[gi]      = busy_reg;
    end
  endgenerate

  // OR the next-state loads so any_load lines up with the load bits
  always_ff @(posedge clock) begin
    if (reset) any_load_reg <= 1'b0;
    else       any_load_reg <= |load_next_vec;
  end

  assign bus.load     = load_vec;
  assign bus.busy     = busy_vec;
  assign bus.any_load = any_load_reg;
endmodule

// File: tb/tb_multi_pulse_gen.sv
// Scoreboard bench for multi_pulse_gen: dut_a uses defaults, dut_b uses PULSE_WIDTH=3.
// Expected pulses are queued as stimulus is driven and matched by a negedge monitor.
module tb_multi_pulse_gen;
  localparam int CH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multi_pulse_gen_if #(.CHANNELS(CH)) bus_a ();
  multi_pulse_gen_if #(.CHANNELS(CH)) bus_b ();

  multi_pulse_gen #(.CHANNELS(CH)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (bus_a)
  );

  multi_pulse_gen #(.CHANNELS(CH), .PULSE_WIDTH(3)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct {
    int dut;
    int ch;
    int start;
    int width;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_pulse(input int d, input int c, input int s, input int w);
    ev_t e;
    e.dut = d; e.ch = c; e.start = s; e.width = w;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: rebuilds each observed pulse and retires the matching expectation
  logic [3:0] prev_load [2];
  int         start_cyc [2][4];
  logic [3:0] cur_load  [2];
  logic       cur_any   [2];
  int         idx, w;

  initial begin
    prev_load[0] = '0;
    prev_load[1] = '0;
  end

  always @(negedge clock) begin
    if (mon_en) begin
      cur_load[0] = bus_a.load;
      cur_load[1] = bus_b.load;
      cur_any[0]  = bus_a.any_load;
      cur_any[1]  = bus_b.any_load;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (cur_any[d] !== (|cur_load[d])) begin
          n_fail++;
          $display("FAIL any_load_or dut%0d cyc %0d: any_load=%b required=%b", d, cyc, cur_any[d], |cur_load[d]);
        end
        for (int c = 0; c < 4; c++) begin
          if (cur_load[d][c] === 1'b1 && prev_load[d][c] !== 1'b1) begin
            start_cyc[d][c] = cyc;
          end else if (cur_load[d][c] !== 1'b1 && prev_load[d][c] === 1'b1) begin
            w = cyc - start_cyc[d][c];
            $display("pulse dut%0d ch%0d start=%0d width=%0d", d, c, start_cyc[d][c], w);
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].dut == d && exp_q[i].ch == c) idx = i;
            n_checks++;
            if (idx < 0) begin
              n_fail++;
              $display("FAIL unexpected_pulse dut%0d ch%0d: start=%0d width=%0d, required no pulse", d, c, start_cyc[d][c], w);
            end else begin
              if (exp_q[idx].start !== start_cyc[d][c] || exp_q[idx].width !== w) begin
                n_fail++;
                $display("FAIL pulse_timing dut%0d ch%0d: start=%0d width=%0d, required start=%0d width=%0d",
                         d, c, start_cyc[d][c], w, exp_q[idx].start, exp_q[idx].width);
              end
              exp_q.delete(idx);
            end
          end
        end
        prev_load[d] = cur_load[d];
      end
    end
  end

  task automatic test_reset();
    int k;
    reset = 1'b1;
    bus_a.enable = '1; bus_b.enable = '1;
    bus_a.trigger = 4'b1000; bus_b.trigger = '0;
    tick(3);
    mon_en = 1'b1;
    n_checks++;
    if (bus_a.load !== 4'b0000 || bus_a.busy !== 4'b0000 || bus_a.any_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_a: load=%b busy=%b any=%b, required all 0", bus_a.load, bus_a.busy, bus_a.any_load);
    end
    n_checks++;
    if (bus_b.load !== 4'b0000 || bus_b.busy !== 4'b0000 || bus_b.any_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_b: load=%b busy=%b any=%b, required all 0", bus_b.load, bus_b.busy, bus_b.any_load);
    end
    // trigger held through reset release is a fresh press
    reset = 1'b0;
    k = cyc;
    expect_pulse(0, 3, k + 6, 1);
    tick(4);
    n_checks++;
    if (bus_a.busy !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_held_busy: busy=%b, required 1000", bus_a.busy);
    end
    tick(6);
    bus_a.trigger[3] = 1'b0;
    tick(10);
    n_checks++;
    if (bus_a.busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_held_release: busy=%b, required 0000", bus_a.busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_reset: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_press();
    int k;
    k = cyc;
    bus_a.trigger[0] = 1'b1;
    expect_pulse(0, 0, k + 6, 1);
    tick(6);
    n_checks++;
    if (bus_a.load !== 4'b0001 || bus_a.any_load !== 1'b1) begin
      n_fail++;
      $display("FAIL press_latency: load=%b any=%b, required 0001/1", bus_a.load, bus_a.any_load);
    end
    tick(1);
    n_checks++;
    if (bus_a.load !== 4'b0000 || bus_a.busy !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_hold: load=%b busy=%b, required 0000/0001", bus_a.load, bus_a.busy);
    end
    tick(33);
    bus_a.trigger[0] = 1'b0;
    tick(10);
    n_checks++;
    if (bus_a.busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_release: busy=%b, required 0000", bus_a.busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_single_press: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    int k;
    k = cyc;
    bus_a.trigger[1] = 1'b1;
    tick(3);
    bus_a.trigger[1] = 1'b0;
    tick(2);
    n_checks++;
    if (bus_a.busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_high: busy[1]=%b at cyc %0d, required 1", bus_a.busy[1], cyc - k);
    end
    tick(1);
    n_checks++;
    if (bus_a.busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_clear: busy[1]=%b at cyc %0d, required 0", bus_a.busy[1], cyc - k);
    end
    tick(6);
    // a burst of exactly DEBOUNCE_CYCLES samples is accepted
    k = cyc;
    bus_a.trigger[1] = 1'b1;
    tick(4);
    bus_a.trigger[1] = 1'b0;
    expect_pulse(0, 1, k + 6, 1);
    tick(12);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_glitch: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pulse_width();
    int k;
    k = cyc;
    bus_b.trigger[2] = 1'b1;
    expect_pulse(1, 2, k + 6, 3);
    tick(6);
    bus_b.trigger[2] = 1'b0;
    tick(2);
    n_checks++;
    if (bus_b.load !== 4'b0100) begin
      n_fail++;
      $display("FAIL width_not_truncated: load=%b, required 0100", bus_b.load);
    end
    bus_b.trigger[2] = 1'b1; tick(2);
    bus_b.trigger[2] = 1'b0; tick(2);
    bus_b.trigger[2] = 1'b1; tick(2);
    bus_b.trigger[2] = 1'b0;
    tick(15);
    n_checks++;
    if (bus_b.busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL bounce_release: busy=%b, required 0000", bus_b.busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_pulse_width: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    int k;
    k = cyc;
    bus_b.trigger[0] = 1'b1;
    bus_b.trigger[3] = 1'b1;
    expect_pulse(1, 0, k + 6, 2);
    expect_pulse(1, 3, k + 6, 2);
    tick(6);
    n_checks++;
    if (bus_b.load !== 4'b1001 || bus_b.any_load !== 1'b1) begin
      n_fail++;
      $display("FAIL simultaneous: load=%b any=%b, required 1001/1", bus_b.load, bus_b.any_load);
    end
    tick(1);
    reset = 1'b1;
    bus_b.trigger = '0;
    tick(1);
    n_checks++;
    if (bus_b.load !== 4'b0000 || bus_b.busy !== 4'b0000 || bus_b.any_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: load=%b busy=%b any=%b, required all 0", bus_b.load, bus_b.busy, bus_b.any_load);
    end
    tick(1);
    reset = 1'b0;
    tick(8);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_simultaneous: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable();
    int k;
    bus_a.enable[0] = 1'b0;
    bus_a.trigger[0] = 1'b1; tick(8);
    bus_a.trigger[0] = 1'b0; tick(8);
    bus_a.trigger[0] = 1'b1; tick(8);
    n_checks++;
    if (bus_a.busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_busy: busy[0]=%b, required 0", bus_a.busy[0]);
    end
    k = cyc;
    bus_a.enable[0] = 1'b1;
    expect_pulse(0, 0, k + 4, 1);
    tick(4);
    n_checks++;
    if (bus_a.load !== 4'b0001) begin
      n_fail++;
      $display("FAIL enable_rise_pulse: load=%b, required 0001", bus_a.load);
    end
    tick(4);
    bus_a.trigger[0] = 1'b0;
    tick(10);
    // disabling mid-pulse truncates it on the next edge
    k = cyc;
    bus_b.trigger[1] = 1'b1;
    expect_pulse(1, 1, k + 6, 1);
    tick(6);
    bus_b.enable[1] = 1'b0;
    tick(1);
    n_checks++;
    if (bus_b.load !== 4'b0000 || bus_b.busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_truncate: load=%b busy[1]=%b, required 0000/0", bus_b.load, bus_b.busy[1]);
    end
    bus_b.trigger[1] = 1'b0;
    tick(6);
    bus_b.enable[1] = 1'b1;
    tick(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_enable: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_repeat();
    int k, p;
    k = cyc;
    p = k + 6;
    bus_a.trigger[0] = 1'b1;
    expect_pulse(0, 0, p, 1);
`ifdef MPG_REPEAT_EN
    for (int n = 16; n <= 56; n += 8) expect_pulse(0, 0, p + n, 1);
`endif
    tick(60);
    bus_a.trigger[0] = 1'b0;
    tick(20);
    n_checks++;
    if (bus_a.busy !== 4'b0000) begin
      n_fail++;
      $display("FAIL repeat_release: busy=%b, required 0000", bus_a.busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_repeat: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus_a.enable = '1; bus_a.trigger = '0;
    bus_b.enable = '1; bus_b.trigger = '0;
    test_reset();
    test_single_press();
    test_glitch();
    test_pulse_width();
    test_simultaneous();
    test_enable();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
